dmem_arbiter: RTL and testbench

Shares the single data-memory port between the processor's data interface (port 0, CPU) and an auxiliary master (port 1, AUX: program loader / debug DMA). It sits between the processor's `mem_*` signals and the data RAM or MMIO decoder. Each cycle it reserves the next bus slot for one master. It routes read data back to the master whose read is outstanding and keeps at most one read in flight.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arb_pick.sv | 35 +++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared owner encoding and bus helpers for the data-memory arbiter.
// No logic of its own; imported by dmem_arbiter and dmem_arb_pick.
package dmem_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_AUX  = 2'd2
  } owner_e;

  // A request with byte reads enabled and no byte writes is a read.
  function automatic logic is_read(input logic [BE_W-1:0] oe, input logic [BE_W-1:0] we);
    return (oe != '0) && (we == '0);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Chooses the owner of the next bus slot; all arbitration policy lives here.
// Build option DMEM_ARB_RR_EN selects round-robin, otherwise AUX has absolute priority.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic   eligible,
  input  logic   m1_req,
  input  logic   ack_now,
  input  owner_e last,
  output owner_e next_owner
);

  logic aux_ok;

`ifdef DMEM_ARB_RR_EN
  // AUX may take a contested slot only if the previous contested slot went to the CPU.
  assign aux_ok = (last != OWNER_AUX);
`else
  logic unused_last;
  assign aux_ok      = 1'b1;
  assign unused_last = ^last;
`endif

  always_comb begin
    next_owner = OWNER_NONE;
    if (eligible) begin
      if (m1_req && !ack_now && aux_ok) begin
        next_owner = OWNER_AUX;
      end else begin
        next_owner = OWNER_CPU;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/AUX data-memory port arbiter: 0-cycle CPU pass-through, >=1-cycle AUX grant, one read in flight.
// Stalls via registered m0_ready / m1_ack; policy set by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BE_W-1:0]   m0_oe,
  input  logic [BE_W-1:0]   m0_we,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_valid,

  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_oe,
  input  logic [BE_W-1:0]   m1_we,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_valid,

  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [BE_W-1:0]   s_oe,
  output logic [BE_W-1:0]   s_we,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_valid,
  input  logic              s_ready,

  output logic              proto_err
);

  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  owner_e              rd_tag_q, rd_tag_d;
  owner_e              pick_owner;
  logic                rd_busy_q, rd_busy_d;
  logic                proto_err_q, proto_err_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0]   wdata_hold_q, wdata_hold_d;

  logic                cpu_req;
  logic                rd_issue;
  logic                rd_pend;
  owner_e              rd_tag_cur;
  logic                eligible;
  logic                ack_now;

  assign cpu_req = (m0_oe != '0);
  assign ack_now = (owner_q == OWNER_AUX);

  // Slave mux; an unowned slot keeps the last address/data to avoid needless toggling.
  always_comb begin
    s_addr  = addr_hold_q;
    s_wdata = wdata_hold_q;
    s_oe    = '0;
    s_we    = '0;
    m1_ack  = 1'b0;
    case (owner_q)
      OWNER_CPU: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_oe    = m0_oe;
        s_we    = cpu_req ? m0_we : '0;
      end
      OWNER_AUX: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_oe    = m1_oe;
        s_we    = m1_we;
        m1_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  assign addr_hold_d  = s_addr;
  assign wdata_hold_d = s_wdata;

  // A read issuing this cycle counts as outstanding so a same-cycle s_valid completes it.
  assign rd_issue   = is_read(s_oe, s_we);
  assign rd_pend    = rd_busy_q | rd_issue;
  assign rd_tag_cur = rd_issue ? owner_q : rd_tag_q;

  assign m0_valid = s_valid & rd_pend & (rd_tag_cur == OWNER_CPU);
  assign m1_valid = s_valid & rd_pend & (rd_tag_cur == OWNER_AUX);
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  assign eligible = s_ready & (~rd_pend | s_valid);

  dmem_arb_pick u_pick (
    .eligible   (eligible),
    .m1_req     (m1_req),
    .ack_now    (ack_now),
    .last       (last_q),
    .next_owner (pick_owner)
  );

  always_comb begin
    owner_d     = pick_owner;
    last_d      = last_q;
    rd_busy_d   = rd_pend & ~s_valid;
    rd_tag_d    = rd_tag_cur;
    proto_err_d = proto_err_q | (cpu_req & (owner_q != OWNER_CPU));
    if (eligible && m1_req) begin
      last_d = pick_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWNER_NONE;
      last_q       <= OWNER_CPU;
      rd_tag_q     <= OWNER_NONE;
      rd_busy_q    <= 1'b0;
      proto_err_q  <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      owner_q      <= owner_d;
      last_q       <= last_d;
      rd_tag_q     <= rd_tag_d;
      rd_busy_q    <= rd_busy_d;
      proto_err_q  <= proto_err_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

  assign m0_ready  = (owner_q == OWNER_CPU);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner sequences, randomized run vs reference model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_oe, m0_we;
  logic        m0_ready, m0_valid;
  logic        m1_req;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_oe, m1_we;
  logic        m1_ack, m1_valid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_oe, s_we;
  logic        s_valid, s_ready;
  logic        proto_err;

  dmem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_oe(m0_oe), .m0_we(m0_we),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_valid(m0_valid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_oe(m1_oe), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_valid(m1_valid),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_oe(s_oe), .s_we(s_we),
    .s_rdata(s_rdata), .s_valid(s_valid), .s_ready(s_ready),
    .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    m0_addr = '0; m0_wdata = 32'hDEAD_BEEF; m0_oe = '0; m0_we = '0;
    m1_req = 1'b0; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; m1_oe = 4'hF; m1_we = 4'hF;
    s_rdata = 32'h0BAD_F00D; s_valid = 1'b0; s_ready = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] flags();
    return {m0_ready, m1_ack, m0_valid, m1_valid, proto_err};
  endfunction

  // Directed vectors: one entry per cycle, expected outputs hand-derived from the arbitration rules.
  typedef struct {
    logic [3:0]  m0_oe, m0_we;
    logic [31:0] m0_addr;
    logic        m1_req, s_valid, s_ready;
    logic [4:0]  e_flags;   // {m0_ready, m1_ack, m0_valid, m1_valid, proto_err}
    logic [3:0]  e_oe, e_we;
    logic [31:0] e_addr, e_wd;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] oe0, we0, input logic [31:0] a0,
                              input logic rq, sv, sr, input logic [4:0] fl,
                              input logic [3:0] eo, ew, input logic [31:0] ea, ewd);
    vec_t v;
    v.m0_oe = oe0; v.m0_we = we0; v.m0_addr = a0; v.m1_req = rq; v.s_valid = sv; v.s_ready = sr;
    v.e_flags = fl; v.e_oe = eo; v.e_we = ew; v.e_addr = ea; v.e_wd = ewd;
    return v;
  endfunction

  // Reference model: slot owner 0=none 1=cpu 2=aux, outstanding reads kept as a queue of owners.
  int          mo_slot, nx_slot;
  int          mo_pend[$], nx_pend[$];
  bit          mo_aux_turn, nx_aux_turn, mo_perr, nx_perr;
  logic [31:0] mo_haddr, nx_haddr, mo_hwd, nx_hwd;
  logic [4:0]  ex_flags;
  logic [3:0]  ex_oe, ex_we;
  logic [31:0] ex_addr, ex_wd;

  task automatic model_reset();
    mo_slot = 0; mo_pend.delete(); mo_aux_turn = 1'b1; mo_perr = 1'b0; mo_haddr = '0; mo_hwd = '0;
  endtask

  task automatic model_eval();
    bit v0, v1, elig, aux_ok;
    v0 = 1'b0; v1 = 1'b0;
    ex_oe = '0; ex_we = '0; ex_addr = mo_haddr; ex_wd = mo_hwd;
    if (mo_slot == 1) begin
      ex_addr = m0_addr; ex_wd = m0_wdata; ex_oe = m0_oe; ex_we = (m0_oe != 0) ? m0_we : 4'h0;
    end else if (mo_slot == 2) begin
      ex_addr = m1_addr; ex_wd = m1_wdata; ex_oe = m1_oe; ex_we = m1_we;
    end
    nx_pend = mo_pend;
    if (ex_oe != 0 && ex_we == 0) nx_pend.push_back(mo_slot);
    if (s_valid && nx_pend.size() != 0) begin
      if (nx_pend[0] == 1) v0 = 1'b1; else v1 = 1'b1;
      void'(nx_pend.pop_front());
    end
    elig = s_ready && (nx_pend.size() == 0);
`ifdef DMEM_ARB_RR_EN
    aux_ok = mo_aux_turn;
`else
    aux_ok = 1'b1;
`endif
    if (!elig) nx_slot = 0;
    else if (m1_req && mo_slot != 2 && aux_ok) nx_slot = 2;
    else nx_slot = 1;
    nx_aux_turn = (elig && m1_req) ? (nx_slot != 2) : mo_aux_turn;
    nx_perr  = mo_perr || (m0_oe != 0 && mo_slot != 1);
    nx_haddr = ex_addr;
    nx_hwd   = ex_wd;
    ex_flags = {mo_slot == 1, mo_slot == 2, v0, v1, mo_perr};
  endtask

  task automatic model_commit();
    if (rst) begin
      model_reset();
    end else begin
      mo_slot = nx_slot; mo_pend = nx_pend; mo_aux_turn = nx_aux_turn;
      mo_perr = nx_perr; mo_haddr = nx_haddr; mo_hwd = nx_hwd;
    end
  endtask

  initial begin
    vec_t tbl[12];
    int   grants[$];
    logic prev_rd;
    logic found;
    int   ncpu, naux, mism;
    logic ack_prev;

    tbl[0]  = mk(4'h0, 4'h0, 32'h000, 0, 0, 1, 5'b00000, 4'h0, 4'h0, 32'h000, 32'h0000_0000);
    tbl[1]  = mk(4'hF, 4'hF, 32'h100, 0, 0, 1, 5'b10000, 4'hF, 4'hF, 32'h100, 32'hDEAD_BEEF);
    tbl[2]  = mk(4'hF, 4'h0, 32'h200, 0, 0, 1, 5'b10000, 4'hF, 4'h0, 32'h200, 32'hDEAD_BEEF);
    tbl[3]  = mk(4'h0, 4'h0, 32'h200, 0, 0, 1, 5'b00000, 4'h0, 4'h0, 32'h200, 32'hDEAD_BEEF);
    tbl[4]  = mk(4'h0, 4'h0, 32'h200, 0, 0, 1, 5'b00000, 4'h0, 4'h0, 32'h200, 32'hDEAD_BEEF);
    tbl[5]  = mk(4'h0, 4'h0, 32'h200, 0, 1, 1, 5'b00100, 4'h0, 4'h0, 32'h200, 32'hDEAD_BEEF);
    tbl[6]  = mk(4'h0, 4'h0, 32'h000, 1, 0, 1, 5'b10000, 4'h0, 4'h0, 32'h000, 32'hDEAD_BEEF);
    tbl[7]  = mk(4'h0, 4'h0, 32'h000, 1, 0, 1, 5'b01000, 4'hF, 4'hF, 32'h040, 32'h1234_5678);
    tbl[8]  = mk(4'h0, 4'h0, 32'h000, 0, 0, 1, 5'b10000, 4'h0, 4'h0, 32'h000, 32'hDEAD_BEEF);
    tbl[9]  = mk(4'h0, 4'h0, 32'h000, 0, 0, 0, 5'b10000, 4'h0, 4'h0, 32'h000, 32'hDEAD_BEEF);
    tbl[10] = mk(4'h0, 4'h0, 32'h000, 0, 0, 1, 5'b00000, 4'h0, 4'h0, 32'h000, 32'hDEAD_BEEF);
    tbl[11] = mk(4'h0, 4'h0, 32'h000, 0, 0, 1, 5'b10000, 4'h0, 4'h0, 32'h000, 32'hDEAD_BEEF);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      m0_oe = tbl[i].m0_oe; m0_we = tbl[i].m0_we; m0_addr = tbl[i].m0_addr;
      m1_req = tbl[i].m1_req; s_valid = tbl[i].s_valid; s_ready = tbl[i].s_ready;
      #5;
      chk($sformatf("vec%0d", i), {flags(), s_oe, s_we, s_addr, s_wdata},
          {tbl[i].e_flags, tbl[i].e_oe, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wd});
      if (tbl[i].e_flags[2]) chk($sformatf("vec%0d_rdata", i), m0_rdata, 32'h0BAD_F00D);
      next_cycle();
    end

    // CPU request in a slot it does not own: dropped, sticky error until reset.
    drive_idle(); s_ready = 1'b0;
    next_cycle();
    s_ready = 1'b1; m0_oe = 4'b0001; m0_addr = 32'h300;
    #5;
    chk("perr_dropped", {m0_ready, s_oe, s_we}, 9'h0);
    next_cycle();
    m0_oe = 4'h0;
    #5;
    chk("perr_set", proto_err, 1'b1);
    next_cycle();
    repeat (3) next_cycle();
    #5;
    chk("perr_sticky", proto_err, 1'b1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #5;
    chk("perr_cleared", {flags(), s_oe, s_we}, 13'h0);
    next_cycle();

    // Continuous AUX and CPU reads, slave answering one cycle after each read.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m1_req = 1'b1; m1_oe = 4'hF; m1_we = 4'h0; m1_addr = 32'h44;
    m0_oe = 4'hF; m0_we = 4'h0; m0_addr = 32'h500;
    prev_rd = 1'b0;
    for (int k = 0; k < 24; k++) begin
      s_valid = prev_rd;
      #5;
      if (m1_ack) grants.push_back(2);
      if (m0_ready) grants.push_back(1);
      prev_rd = (s_oe != 0) && (s_we == 0);
      next_cycle();
    end
    ncpu = 0; naux = 0; mism = 0;
    foreach (grants[g]) begin
      if (grants[g] == 1) ncpu++; else naux++;
      if (grants[g] != ((g % 2 == 0) ? 2 : 1)) mism++;
    end
`ifdef DMEM_ARB_RR_EN
    chk("rr_grant_count", grants.size(), 12);
    chk("rr_alternation", mism, 0);
`else
    chk("prio_cpu_slots", ncpu, 0);
    chk("prio_aux_slots", naux, 12);
`endif
    m1_req = 1'b0; m0_oe = 4'h0;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      s_valid = prev_rd;
      #5;
      found = m0_ready;
      prev_rd = (s_oe != 0) && (s_we == 0);
      next_cycle();
    end
    chk("cpu_regains_slot", found, 1'b1);

    // Reset while an AUX read is outstanding: late s_valid must be ignored.
    drive_idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m1_req = 1'b1; m1_oe = 4'hF; m1_we = 4'h0; m1_addr = 32'h80;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      #5;
      found = m1_ack;
      next_cycle();
    end
    chk("rstrd_ack_seen", found, 1'b1);
    m1_req = 1'b0;
    #5;
    chk("rstrd_pending", {m1_valid, m0_ready}, 2'b00);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; s_valid = 1'b1;
    #5;
    chk("rstrd_outputs", {flags(), s_oe, s_we, s_addr}, 45'h0);
    next_cycle();

    // Randomized run against the reference model.
    drive_idle();
    rst = 1'b1;
    next_cycle();
    model_reset();
    ack_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (m1_req && ack_prev) m1_req = 1'b0;
      if (!m1_req && $urandom_range(0, 3) == 0) begin
        m1_req = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
        m1_oe = 4'($urandom_range(1, 15));
        m1_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      if (mo_slot == 1 || $urandom_range(0, 15) == 0)
        m0_oe = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      else
        m0_oe = 4'h0;
      m0_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      m0_addr = $urandom; m0_wdata = $urandom; s_rdata = $urandom;
      s_valid = ($urandom_range(0, 2) == 0);
      s_ready = ($urandom_range(0, 4) != 0);
      #5;
      model_eval();
      chk($sformatf("rand%0d", i),
          {flags(), s_oe, s_we, s_addr, s_wdata, m0_rdata, m1_rdata},
          {ex_flags, ex_oe, ex_we, ex_addr, ex_wd, s_rdata, s_rdata});
      ack_prev = ex_flags[3];
      @(posedge clk);
      model_commit();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
